// File: rtl/exec_stage_mc_if.sv
// Bundles the execute-stage handshake, operand and EX/MEM result signals.
// slave is the stage's view; master is the driving (upstream/downstream) view.
interface exec_stage_mc_if #(
  parameter int N  = 24,
  parameter int RW = 4
);
  logic          flush, stall_in, in_valid;
  logic [N-1:0]  rd1, rd2, rd3, pc, imm, fwd_mem, fwd_wb;
  logic [1:0]    fwd_a, fwd_b;
  logic          imm_src;
  logic [3:0]    alu_ctrl;
  logic [RW-1:0] rc;
  logic          branch, mem_write, mem_to_reg, reg_write;
  logic [1:0]    op_type;
  logic [3:0]    op_code;

  logic          stall_out, out_valid;
  logic [N-1:0]  out_result;
  logic          out_zero, out_neg;
  logic          out_branch, out_mem_write, out_mem_to_reg, out_reg_write;
  logic [RW-1:0] out_rc;
  logic [N-1:0]  out_rd3;
  logic [1:0]    out_op_type;
  logic [3:0]    out_op_code;

  modport slave (
    input  flush, stall_in, in_valid, rd1, rd2, rd3, pc, imm, fwd_mem, fwd_wb,
           fwd_a, fwd_b, imm_src, alu_ctrl, rc, branch, mem_write, mem_to_reg,
           reg_write, op_type, op_code,
    output stall_out, out_valid, out_result, out_zero, out_neg, out_branch,
           out_mem_write, out_mem_to_reg, out_reg_write, out_rc, out_rd3,
           out_op_type, out_op_code
  );

  modport master (
    output flush, stall_in, in_valid, rd1, rd2, rd3, pc, imm, fwd_mem, fwd_wb,
           fwd_a, fwd_b, imm_src, alu_ctrl, rc, branch, mem_write, mem_to_reg,
           reg_write, op_type, op_code,
    input  stall_out, out_valid, out_result, out_zero, out_neg, out_branch,
           out_mem_write, out_mem_to_reg, out_reg_write, out_rc, out_rd3,
           out_op_type, out_op_code
  );
endinterface

// File: rtl/exec_stage_mc.sv
// Execute stage with EX/MEM register and iterative shift-add multiply.
// Define EXEC_DIV_EN to add an iterative unsigned restoring divide on alu_ctrl=10.
module exec_stage_mc #(
  parameter int N  = 24,
  parameter int RW = 4,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  exec_stage_mc_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;

  logic [CW-1:0] count;
  logic [N-1:0]  acc, mcand, mplier;
  logic [RW-1:0] m_rc;
  logic [N-1:0]  m_rd3;
  logic          m_branch, m_mem_write, m_mem_to_reg, m_reg_write;
  logic [1:0]    m_op_type;
  logic [3:0]    m_op_code;
`ifdef EXEC_DIV_EN
  logic          m_div;
  logic [N:0]    rem_sh, rem_diff;
`endif

  logic [N-1:0]  a_op, b_op, alu_res, step_acc, step_mplier, mc_res;
  logic [CW-2:0] shamt;
  logic          shift_oob, mc_op, accept_mc, last_step;

  always_comb begin
    case (bus.fwd_a)
      2'b00:   a_op = bus.rd1;
      2'b01:   a_op = bus.fwd_mem;
      2'b10:   a_op = bus.fwd_wb;
      default: a_op = bus.pc;
    endcase
    case (bus.fwd_b)
      2'b01:   b_op = bus.fwd_mem;
      2'b10:   b_op = bus.fwd_wb;
      default: b_op = bus.rd2;
    endcase
    if (bus.imm_src) b_op = bus.imm;
  end

  assign shamt     = b_op[CW-2:0];
  assign shift_oob = 32'(shamt) >= N;

  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      4'd0: alu_res = a_op + b_op;
      4'd1: alu_res = a_op - b_op;
      4'd2: alu_res = a_op & b_op;
      4'd3: alu_res = a_op | b_op;
      4'd4: alu_res = a_op ^ b_op;
      4'd5: alu_res = shift_oob ? '0 : a_op << shamt;
      4'd6: alu_res = shift_oob ? '0 : a_op >> shamt;
      4'd7: alu_res = shift_oob ? {N{a_op[N-1]}} : $unsigned($signed(a_op) >>> shamt);
      4'd9: alu_res = b_op;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_DIV_EN
  assign mc_op = (bus.alu_ctrl == 4'd8) || (bus.alu_ctrl == 4'd10);
`else
  assign mc_op = (bus.alu_ctrl == 4'd8);
`endif

  // Multiply: acc += mcand when the current multiplier LSB is set.
  // Divide reuses acc as remainder and mplier as the dividend/quotient shifter.
  always_comb begin
    step_acc    = acc + (mplier[0] ? mcand : '0);
    step_mplier = mplier >> 1;
    mc_res      = step_acc;
`ifdef EXEC_DIV_EN
    rem_sh   = {acc, mplier[N-1]};
    rem_diff = rem_sh - {1'b0, mcand};
    if (m_div) begin
      if (rem_sh >= {1'b0, mcand}) begin
        step_acc    = rem_diff[N-1:0];
        step_mplier = {mplier[N-2:0], 1'b1};
      end else begin
        step_acc    = rem_sh[N-1:0];
        step_mplier = {mplier[N-2:0], 1'b0};
      end
      mc_res = step_mplier;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush)              state_next = IDLE;
    else if (!bus.stall_in) begin
      if (state == IDLE && accept_mc) state_next = BUSY;
      else if (state == BUSY && last_step) state_next = IDLE;
    end
  end

  always_comb begin
    accept_mc     = (state == IDLE) && bus.in_valid && mc_op;
    last_step     = (state == BUSY) && (count == CW'(N - 1));
    bus.stall_out = bus.stall_in || accept_mc || ((state == BUSY) && !last_step);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0; acc <= '0; mcand <= '0; mplier <= '0;
      m_rc <= '0; m_rd3 <= '0; m_op_type <= '0; m_op_code <= '0;
      m_branch <= 1'b0; m_mem_write <= 1'b0; m_mem_to_reg <= 1'b0; m_reg_write <= 1'b0;
`ifdef EXEC_DIV_EN
      m_div <= 1'b0;
`endif
      bus.out_valid <= 1'b0; bus.out_result <= '0; bus.out_zero <= 1'b0; bus.out_neg <= 1'b0;
      bus.out_branch <= 1'b0; bus.out_mem_write <= 1'b0;
      bus.out_mem_to_reg <= 1'b0; bus.out_reg_write <= 1'b0;
      bus.out_rc <= '0; bus.out_rd3 <= '0; bus.out_op_type <= '0; bus.out_op_code <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0; bus.out_branch <= 1'b0; bus.out_mem_write <= 1'b0;
      bus.out_mem_to_reg <= 1'b0; bus.out_reg_write <= 1'b0;
    end else if (!bus.stall_in) begin
      if (state == IDLE && !accept_mc) begin
        bus.out_valid      <= bus.in_valid;
        bus.out_branch     <= bus.branch     & bus.in_valid;
        bus.out_mem_write  <= bus.mem_write  & bus.in_valid;
        bus.out_mem_to_reg <= bus.mem_to_reg & bus.in_valid;
        bus.out_reg_write  <= bus.reg_write  & bus.in_valid;
        bus.out_result     <= alu_res;
        bus.out_zero       <= (alu_res == '0);
        bus.out_neg        <= alu_res[N-1];
        bus.out_rc         <= bus.rc;
        bus.out_rd3        <= bus.rd3;
        bus.out_op_type    <= bus.op_type;
        bus.out_op_code    <= bus.op_code;
      end else if (state == BUSY && last_step) begin
        bus.out_valid      <= 1'b1;
        bus.out_branch     <= m_branch;
        bus.out_mem_write  <= m_mem_write;
        bus.out_mem_to_reg <= m_mem_to_reg;
        bus.out_reg_write  <= m_reg_write;
        bus.out_result     <= mc_res;
        bus.out_zero       <= (mc_res == '0);
        bus.out_neg        <= mc_res[N-1];
        bus.out_rc         <= m_rc;
        bus.out_rd3        <= m_rd3;
        bus.out_op_type    <= m_op_type;
        bus.out_op_code    <= m_op_code;
      end else begin
        bus.out_valid <= 1'b0; bus.out_branch <= 1'b0; bus.out_mem_write <= 1'b0;
        bus.out_mem_to_reg <= 1'b0; bus.out_reg_write <= 1'b0;
      end

      if (accept_mc) begin
        count <= '0; acc <= '0;
        mcand <= a_op; mplier <= b_op;
`ifdef EXEC_DIV_EN
        m_div <= (bus.alu_ctrl == 4'd10);
        if (bus.alu_ctrl == 4'd10) begin
          mcand <= b_op; mplier <= a_op;
        end
`endif
        m_rc <= bus.rc; m_rd3 <= bus.rd3; m_op_type <= bus.op_type; m_op_code <= bus.op_code;
        m_branch <= bus.branch; m_mem_write <= bus.mem_write;
        m_mem_to_reg <= bus.mem_to_reg; m_reg_write <= bus.reg_write;
      end else if (state == BUSY) begin
        count  <= count + CW'(1);
        acc    <= step_acc;
        mplier <= step_mplier;
`ifdef EXEC_DIV_EN
        mcand  <= m_div ? mcand : mcand << 1;
`else
        mcand  <= mcand << 1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed vector table for single-cycle ops plus hand-written multi-cycle,
// flush and reset sequences for exec_stage_mc at N=24.
module tb_exec_stage_mc;
  localparam int N = 24;
  localparam logic [23:0] FM = 24'hAAAAAA, FW = 24'h555555, PCV = 24'h0F0F0F, IM = 24'h333333;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exec_stage_mc_if #(.N(N), .RW(4)) bus ();
  exec_stage_mc #(.N(N), .RW(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  fa, fb;
    logic        ii;
    logic [23:0] rd1, rd2, fm, fw, pc, im;
    logic        v, st, fl;
    logic [3:0]  rc;
    logic [23:0] er;
    logic        ez, en, ev, erw;
    logic [3:0]  erc;
    logic        eso, chk;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic void addv(
    input logic [3:0] op, input logic [1:0] fa, input logic [1:0] fb, input logic ii,
    input logic [23:0] rd1, input logic [23:0] rd2, input logic [23:0] fm,
    input logic [23:0] fw, input logic [23:0] pc, input logic [23:0] im,
    input logic v, input logic st, input logic fl, input logic [3:0] rc,
    input logic [23:0] er, input logic ez, input logic en, input logic ev,
    input logic erw, input logic [3:0] erc, input logic eso, input logic chk);
    vec_t t;
    t.op = op; t.fa = fa; t.fb = fb; t.ii = ii; t.rd1 = rd1; t.rd2 = rd2;
    t.fm = fm; t.fw = fw; t.pc = pc; t.im = im; t.v = v; t.st = st; t.fl = fl;
    t.rc = rc; t.er = er; t.ez = ez; t.en = en; t.ev = ev; t.erw = erw;
    t.erc = erc; t.eso = eso; t.chk = chk;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b, input logic [3:0] rc);
    bus.alu_ctrl = op; bus.fwd_a = 2'b00; bus.fwd_b = 2'b00; bus.imm_src = 1'b0;
    bus.rd1 = a; bus.rd2 = b; bus.rc = rc; bus.in_valid = 1'b1;
    bus.fwd_mem = FM; bus.fwd_wb = FW; bus.pc = PCV; bus.imm = IM;
  endtask

  // Upstream holds the MUL while stall_out is high and drops it once consumed.
  task automatic run_mul(input string nm, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] exp, input int s0, input int slen);
    int stalls = 0, valids = 0, done_c = -1;
    logic st;
    logic [23:0] got = '0;
    logic [3:0] got_rc = '0;
    logic [23:0] got_rd3 = '0;
    logic got_z = 1'b0, got_n = 1'b0, got_rw = 1'b0;
    @(negedge clk);
    drive_op(4'd8, a, b, 4'h6);
    bus.rd3 = 24'h00ABCD;
    for (int c = 0; c < 40; c++) begin
      bus.stall_in = (c >= s0) && (c < s0 + slen);
      #1;
      st = bus.stall_out;
      if (st) stalls++;
      @(posedge clk); #1;
      if (bus.out_valid) begin
        valids++; done_c = c; got = bus.out_result; got_rc = bus.out_rc;
        got_rd3 = bus.out_rd3; got_z = bus.out_zero; got_n = bus.out_neg;
        got_rw = bus.out_reg_write;
      end
      @(negedge clk);
      if (!st) bus.in_valid = 1'b0;
    end
    bus.stall_in = 1'b0;
    chk({nm, "_stall_cycles"}, stalls, N + slen);
    chk({nm, "_valid_count"}, valids, 1);
    chk({nm, "_done_cycle"}, done_c, N + slen);
    chk({nm, "_result"}, got, exp);
    chk({nm, "_zero"}, got_z, exp == 24'h0);
    chk({nm, "_neg"}, got_n, exp[23]);
    chk({nm, "_rc"}, got_rc, 4'h6);
    chk({nm, "_rd3"}, got_rd3, 24'h00ABCD);
    chk({nm, "_reg_write"}, got_rw, 1'b1);
  endtask

  initial begin
    int bad_valid;
    bus.flush = 0; bus.stall_in = 0; bus.in_valid = 0;
    bus.rd1 = '0; bus.rd2 = '0; bus.rd3 = '0; bus.pc = '0; bus.imm = '0;
    bus.fwd_mem = '0; bus.fwd_wb = '0; bus.fwd_a = '0; bus.fwd_b = '0;
    bus.imm_src = 0; bus.alu_ctrl = '0; bus.rc = '0;
    bus.branch = 0; bus.mem_write = 0; bus.mem_to_reg = 0; bus.reg_write = 1;
    bus.op_type = 2'b10; bus.op_code = 4'h5;

    //    op fa fb ii rd1          rd2          fm       fw          pc          im       v st fl rc  er           ez en ev rw erc so chk
    addv(0, 0, 0, 0, 24'h5,      24'h3,      FM,      FW,         PCV,        IM,      1, 0, 0, 1,  24'h8,      0, 0, 1, 1, 1,  0, 1);
    addv(4, 0, 0, 0, 24'h1,      24'h2,      FM,      FW,         PCV,        IM,      1, 1, 0, 2,  24'h8,      0, 0, 1, 1, 1,  1, 1);
    addv(1, 1, 0, 1, 24'h0,      24'h0,      24'h10,  FW,         PCV,        24'h10,  1, 0, 0, 3,  24'h0,      1, 0, 1, 1, 3,  0, 1);
    addv(2, 0, 0, 0, 24'hF0F0F0, 24'h0FF0FF, FM,      FW,         PCV,        IM,      1, 0, 0, 4,  24'h00F0F0, 0, 0, 1, 1, 4,  0, 1);
    addv(3, 0, 2, 0, 24'h1,      24'h0,      FM,      24'h800000, PCV,        IM,      1, 0, 0, 5,  24'h800001, 0, 1, 1, 1, 5,  0, 1);
    addv(4, 0, 0, 0, 24'hFFFFFF, 24'hFFFFFF, FM,      FW,         PCV,        IM,      1, 0, 0, 6,  24'h0,      1, 0, 1, 1, 6,  0, 1);
    addv(5, 0, 0, 0, 24'h1,      24'd23,     FM,      FW,         PCV,        IM,      1, 0, 0, 7,  24'h800000, 0, 1, 1, 1, 7,  0, 1);
    addv(5, 0, 0, 0, 24'h1,      24'd24,     FM,      FW,         PCV,        IM,      1, 0, 0, 8,  24'h0,      1, 0, 1, 1, 8,  0, 1);
    addv(6, 3, 0, 0, 24'h0,      24'd4,      FM,      FW,         24'h800000, IM,      1, 0, 0, 9,  24'h080000, 0, 0, 1, 1, 9,  0, 1);
    addv(7, 0, 0, 0, 24'h800000, 24'd30,     FM,      FW,         PCV,        IM,      1, 0, 0, 10, 24'hFFFFFF, 0, 1, 1, 1, 10, 0, 1);
    addv(7, 0, 0, 0, 24'h800000, 24'd4,      FM,      FW,         PCV,        IM,      1, 0, 0, 11, 24'hF80000, 0, 1, 1, 1, 11, 0, 1);
    addv(9, 0, 3, 0, 24'h0,      24'h123456, FM,      FW,         PCV,        IM,      1, 0, 0, 12, 24'h123456, 0, 0, 1, 1, 12, 0, 1);
    addv(15,0, 0, 0, 24'h5,      24'h3,      FM,      FW,         PCV,        IM,      1, 0, 0, 13, 24'h0,      1, 0, 1, 1, 13, 0, 1);
    addv(1, 0, 0, 0, 24'h3,      24'h5,      FM,      FW,         PCV,        IM,      1, 0, 0, 14, 24'hFFFFFE, 0, 1, 1, 1, 14, 0, 1);
    addv(0, 0, 0, 0, 24'hFFFFFF, 24'h2,      FM,      FW,         PCV,        IM,      1, 0, 0, 15, 24'h1,      0, 0, 1, 1, 15, 0, 1);
    addv(0, 0, 0, 0, 24'h1,      24'h1,      FM,      FW,         PCV,        IM,      0, 0, 0, 0,  24'h0,      0, 0, 0, 0, 0,  0, 0);
    addv(0, 0, 0, 0, 24'h1,      24'h1,      FM,      FW,         PCV,        IM,      1, 0, 1, 3,  24'h0,      0, 0, 0, 0, 0,  0, 0);
    addv(0, 0, 0, 0, 24'h1,      24'h1,      FM,      FW,         PCV,        IM,      1, 1, 1, 3,  24'h0,      0, 0, 0, 0, 0,  1, 0);
    addv(0, 2, 0, 0, 24'h0,      24'h23,     FM,      24'h100,    PCV,        IM,      1, 0, 0, 9,  24'h123,    0, 0, 1, 1, 9,  0, 1);
    addv(1, 0, 1, 0, 24'hAAAAAB, 24'h0,      FM,      FW,         PCV,        IM,      1, 0, 0, 2,  24'h1,      0, 0, 1, 1, 2,  0, 1);

    repeat (2) @(negedge clk);
    chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_result", bus.out_result, 24'h0);
    chk("reset_reg_write", bus.out_reg_write, 1'b0);
    chk("reset_op_code", bus.out_op_code, 4'h0);
    rst = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      bus.alu_ctrl = vq[i].op; bus.fwd_a = vq[i].fa; bus.fwd_b = vq[i].fb;
      bus.imm_src = vq[i].ii; bus.rd1 = vq[i].rd1; bus.rd2 = vq[i].rd2;
      bus.fwd_mem = vq[i].fm; bus.fwd_wb = vq[i].fw; bus.pc = vq[i].pc; bus.imm = vq[i].im;
      bus.in_valid = vq[i].v; bus.stall_in = vq[i].st; bus.flush = vq[i].fl; bus.rc = vq[i].rc;
      #1;
      chk($sformatf("v%0d_stall_out", i), bus.stall_out, vq[i].eso);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), bus.out_valid, vq[i].ev);
      chk($sformatf("v%0d_reg_write", i), bus.out_reg_write, vq[i].erw);
      if (vq[i].chk) begin
        chk($sformatf("v%0d_result", i), bus.out_result, vq[i].er);
        chk($sformatf("v%0d_zero", i), bus.out_zero, vq[i].ez);
        chk($sformatf("v%0d_neg", i), bus.out_neg, vq[i].en);
        chk($sformatf("v%0d_rc", i), bus.out_rc, vq[i].erc);
      end
    end
    @(negedge clk);
    bus.stall_in = 0; bus.flush = 0; bus.in_valid = 0;

    run_mul("mul_basic", 24'h7, 24'h6, 24'h00002A, 100, 0);
    run_mul("mul_stall", 24'h7, 24'h6, 24'h00002A, 5, 3);
    run_mul("mul_ones", 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 100, 0);
    run_mul("mul_wrap", 24'h123456, 24'h000100, 24'h345600, 100, 0);

    // Flush at count=10: accept edge plus ten busy edges precede the flush cycle.
    @(negedge clk);
    drive_op(4'd8, 24'h7, 24'h6, 4'h6);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); @(negedge clk);
    end
    bus.flush = 1'b1; bus.in_valid = 1'b0;
    #1;
    chk("flush_cycle_stall_out", bus.stall_out, 1'b1);
    @(posedge clk); #1;
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_reg_write", bus.out_reg_write, 1'b0);
    chk("flush_stall_out", bus.stall_out, 1'b0);
    @(negedge clk);
    bus.flush = 1'b0;
    bad_valid = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.stall_out) bad_valid++;
    end
    chk("flush_discarded", bad_valid, 0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    drive_op(4'd8, 24'h7, 24'h6, 4'h6);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_result", bus.out_result, 24'h0);
    chk("rst_mid_valid", bus.out_valid, 1'b0);
    chk("rst_mid_rc", bus.out_rc, 4'h0);
    chk("rst_mid_op_type", bus.out_op_type, 2'b00);
    chk("rst_mid_flags", {bus.out_zero, bus.out_neg, bus.out_reg_write}, 3'b000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    drive_op(4'd0, 24'h2, 24'h2, 4'h3);
    #1;
    chk("post_rst_stall_out", bus.stall_out, 1'b0);
    @(posedge clk); #1;
    chk("post_rst_result", bus.out_result, 24'h4);
    chk("post_rst_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
